// File: rtl/regfile_if.sv
// Register file bus between the processor and the register file.
// The processor (master) drives read indices from decode and the write
// request from writeback; the register file (slave) returns operands.
interface regfile_if;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   logic [4:0]  ctrl_readRegA;
   logic [4:0]  ctrl_readRegB;
   logic [4:0]  ctrl_readRegDbg;
   logic [31:0] data_readRegA;
   logic [31:0] data_readRegB;
   logic [31:0] data_readRegDbg;

   modport master (
      output ctrl_writeEnable,
      output ctrl_writeReg,
      output data_writeReg,
      output ctrl_readRegA,
      output ctrl_readRegB,
      output ctrl_readRegDbg,
      input  data_readRegA,
      input  data_readRegB,
      input  data_readRegDbg
   );

   modport slave (
      input  ctrl_writeEnable,
      input  ctrl_writeReg,
      input  data_writeReg,
      input  ctrl_readRegA,
      input  ctrl_readRegB,
      input  ctrl_readRegDbg,
      output data_readRegA,
      output data_readRegB,
      output data_readRegDbg
   );
endinterface

// File: rtl/regfile.sv
// 32 x 32-bit general-purpose register file with r0 hardwired to zero.
// Two operand read ports (A, B) with optional write-to-read bypass, and a
// debug read port that always shows the stored value.
module regfile #(
   parameter bit WRITE_BYPASS = 1'b0
) (
   input logic       clock,
   input logic       reset,
   regfile_if.slave  rf
);

   // r0 has no storage; only r1..r31 exist as flops.
   logic [31:0] regs [1:31];
   logic [31:1] write_sel;
   logic        hit_a;
   logic        hit_b;
   logic [31:0] stored_a;
   logic [31:0] stored_b;
   logic [31:0] stored_dbg;

   // 32:1 read multiplexer; index 0 (and anything unmatched) yields zero.
   function automatic logic [31:0] read_port(input logic [4:0] idx);
      logic [31:0] value;
      value = 32'h0000_0000;
      for (int i = 1; i < 32; i++) begin
         if (idx == 5'(i)) begin
            value = regs[i];
         end
      end
      return value;
   endfunction

   // One-hot write decoder gated by the write enable; bit 0 is never produced.
   always_comb begin
      write_sel = '0;
      for (int i = 1; i < 32; i++) begin
         write_sel[i] = rf.ctrl_writeEnable && (rf.ctrl_writeReg == 5'(i));
      end
   end

   // Register storage: asynchronous clear, otherwise commit the selected register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 1; i < 32; i++) begin
            regs[i] <= 32'h0000_0000;
         end
      end else begin
         for (int i = 1; i < 32; i++) begin
            if (write_sel[i]) begin
               regs[i] <= rf.data_writeReg;
            end
         end
      end
   end

   // Stored-value read for all three ports.
   always_comb begin
      stored_a   = read_port(rf.ctrl_readRegA);
      stored_b   = read_port(rf.ctrl_readRegB);
      stored_dbg = read_port(rf.ctrl_readRegDbg);
   end

   // Bypass hit detection; a write to r0 never bypasses so index 0 still reads zero.
   always_comb begin
      hit_a = rf.ctrl_writeEnable && (rf.ctrl_writeReg != 5'd0) &&
              (rf.ctrl_writeReg == rf.ctrl_readRegA);
      hit_b = rf.ctrl_writeEnable && (rf.ctrl_writeReg != 5'd0) &&
              (rf.ctrl_writeReg == rf.ctrl_readRegB);
   end

   assign rf.data_readRegA   = (WRITE_BYPASS && hit_a) ? rf.data_writeReg : stored_a;
   assign rf.data_readRegB   = (WRITE_BYPASS && hit_b) ? rf.data_writeReg : stored_b;
   assign rf.data_readRegDbg = stored_dbg;

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: one instance with write bypass and one
// without, driven identically and compared against an array reference model.
module tb_regfile;

   logic        clock;
   logic        reset;
   logic        cur_we;
   logic [4:0]  cur_wr;
   logic [31:0] cur_wd;
   logic [4:0]  cur_ra;
   logic [4:0]  cur_rb;
   logic [4:0]  cur_rd;

   logic [31:0] model [32];
   int          n_asserts;
   int          n_fail;

   regfile_if bus_byp ();
   regfile_if bus_nob ();

   assign bus_byp.ctrl_writeEnable = cur_we;
   assign bus_byp.ctrl_writeReg    = cur_wr;
   assign bus_byp.data_writeReg    = cur_wd;
   assign bus_byp.ctrl_readRegA    = cur_ra;
   assign bus_byp.ctrl_readRegB    = cur_rb;
   assign bus_byp.ctrl_readRegDbg  = cur_rd;

   assign bus_nob.ctrl_writeEnable = cur_we;
   assign bus_nob.ctrl_writeReg    = cur_wr;
   assign bus_nob.data_writeReg    = cur_wd;
   assign bus_nob.ctrl_readRegA    = cur_ra;
   assign bus_nob.ctrl_readRegB    = cur_rb;
   assign bus_nob.ctrl_readRegDbg  = cur_rd;

   regfile #(.WRITE_BYPASS(1'b1)) dut_byp (.clock(clock), .reset(reset), .rf(bus_byp.slave));
   regfile #(.WRITE_BYPASS(1'b0)) dut_nob (.clock(clock), .reset(reset), .rf(bus_nob.slave));

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_asserts++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Reference read: r0 is zero, a matching live write bypasses on A/B when enabled.
   function automatic logic [31:0] expectRead(input logic [4:0] idx, input bit bypass_port);
      if (idx == 5'd0) return 32'h0;
      if (bypass_port && cur_we && cur_wr != 5'd0 && cur_wr == idx) return cur_wd;
      return model[idx];
   endfunction

   task automatic clearModel();
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
   endtask

   task automatic applyStimulus(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                                input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd);
      cur_we = we;
      cur_wr = wr;
      cur_wd = wd;
      cur_ra = ra;
      cur_rb = rb;
      cur_rd = rd;
      #1;
   endtask

   // Advance one rising edge and commit the same write to the model.
   task automatic clockEdge();
      @(posedge clock);
      if (!reset && cur_we && cur_wr != 5'd0) model[cur_wr] = cur_wd;
      #1;
   endtask

   task automatic checkOutput(input string tag);
      check({tag, ".bypA"},   bus_byp.data_readRegA,   expectRead(cur_ra, 1'b1));
      check({tag, ".bypB"},   bus_byp.data_readRegB,   expectRead(cur_rb, 1'b1));
      check({tag, ".bypDbg"}, bus_byp.data_readRegDbg, expectRead(cur_rd, 1'b0));
      check({tag, ".nobA"},   bus_nob.data_readRegA,   expectRead(cur_ra, 1'b0));
      check({tag, ".nobB"},   bus_nob.data_readRegB,   expectRead(cur_rb, 1'b0));
      check({tag, ".nobDbg"}, bus_nob.data_readRegDbg, expectRead(cur_rd, 1'b0));
   endtask

   initial begin
      n_asserts = 0;
      n_fail    = 0;
      clearModel();
      reset = 1'b1;
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd1, 5'd31, 5'd5);
      #2;
      checkOutput("reset_init");
      #9;
      reset = 1'b0;
      #1;

      // Asynchronous reset between edges
      applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd5);
      clockEdge();
      check("r5_written", bus_byp.data_readRegDbg, 32'hDEAD_BEEF);
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);
      #1;
      reset = 1'b1;
      clearModel();
      #1;
      check("async_reset_dbg_r5", bus_byp.data_readRegDbg, 32'h0);
      checkOutput("async_reset");
      reset = 1'b0;
      #1;

      // Basic write/read
      applyStimulus(1'b1, 5'd3, 32'h0000_0007, 5'd0, 5'd0, 5'd4);
      clockEdge();
      applyStimulus(1'b1, 5'd31, 32'hFFFF_FFFF, 5'd3, 5'd0, 5'd4);
      clockEdge();
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd31, 5'd4);
      check("basic_A_r3",   bus_nob.data_readRegA,   32'h0000_0007);
      check("basic_B_r31",  bus_nob.data_readRegB,   32'hFFFF_FFFF);
      check("basic_r4_zero", bus_nob.data_readRegDbg, 32'h0);
      checkOutput("basic");

      // r0 protection
      applyStimulus(1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0, 5'd0);
      checkOutput("r0_pre");
      clockEdge();
      checkOutput("r0_post");
      for (int i = 1; i < 32; i++) begin
         applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'(i));
         checkOutput($sformatf("r0_sweep_r%0d", i));
      end

      // Enable gating
      applyStimulus(1'b1, 5'd7, 32'h0000_0011, 5'd7, 5'd7, 5'd7);
      clockEdge();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 5'd7, 32'hAAAA_AAAA, 5'd7, 5'd7, 5'd7);
         clockEdge();
         check($sformatf("gate_r7_edge%0d", k), bus_byp.data_readRegA, 32'h0000_0011);
         checkOutput($sformatf("gate_edge%0d", k));
      end

      // Bypass versus stored value
      applyStimulus(1'b1, 5'd9, 32'h0000_0001, 5'd0, 5'd0, 5'd0);
      clockEdge();
      applyStimulus(1'b1, 5'd9, 32'h0000_0002, 5'd9, 5'd9, 5'd9);
      check("byp_pre_A",   bus_byp.data_readRegA,   32'h0000_0002);
      check("byp_pre_B",   bus_byp.data_readRegB,   32'h0000_0002);
      check("byp_pre_Dbg", bus_byp.data_readRegDbg, 32'h0000_0001);
      check("nob_pre_A",   bus_nob.data_readRegA,   32'h0000_0001);
      check("nob_pre_B",   bus_nob.data_readRegB,   32'h0000_0001);
      checkOutput("byp_pre");
      clockEdge();
      check("byp_post_Dbg", bus_byp.data_readRegDbg, 32'h0000_0002);
      check("nob_post_A",   bus_nob.data_readRegA,   32'h0000_0002);
      checkOutput("byp_post");

      // Reset and write colliding at the same edge
      applyStimulus(1'b1, 5'd10, 32'h0000_0005, 5'd1, 5'd2, 5'd10);
      reset = 1'b1;
      clearModel();
      clockEdge();
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd10, 5'd10, 5'd10);
      check("collide_r10", bus_byp.data_readRegDbg, 32'h0);
      reset = 1'b0;
      #1;
      clockEdge();
      checkOutput("collide_after");

      // Random writes and reads against the model
      for (int n = 0; n < 1000; n++) begin
         applyStimulus(($urandom % 4) != 0, 5'($urandom), $urandom,
                       5'($urandom), 5'($urandom), 5'($urandom));
         if (($urandom % 3) == 0) begin
            cur_ra = cur_wr;
            #1;
         end
         checkOutput($sformatf("rand%0d_pre", n));
         clockEdge();
         checkOutput($sformatf("rand%0d_post", n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
